// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single unified memory port: fetch (read-only) and load/store.
// Grants alternate under contention, accesses are held for ACCESS_CYCLES, and misaligned or out-of-range requests complete without touching memory.
module mem_port_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int MEM_BYTES     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_memData,
  output logic [1:0]  dbg_state
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);
  localparam logic [31:0]   MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          gnt_d_q;
  logic          last_d_q;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   if_rdata_q, d_rdata_q;
  logic          if_ready_q, d_ready_q, if_err_q, d_err_q;

  logic        pick_d;
  logic [31:0] sel_addr;
  logic        sel_err;

  // Data wins only when fetch is idle or fetch was the last one served.
  assign pick_d   = d_req & (~if_req | ~last_d_q);
  assign sel_addr = pick_d ? d_addr : if_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gnt_d_q    <= 1'b0;
      last_d_q   <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req || d_req) begin
            gnt_d_q <= pick_d;
            addr_q  <= sel_addr;
            we_q    <= pick_d & d_we;
            wdata_q <= pick_d ? d_wdata : 32'd0;
            cnt_q   <= '0;
            if (sel_err) begin
              state_q <= S_RESP;
              if (pick_d) begin
                d_ready_q <= 1'b1;
                d_err_q   <= 1'b1;
                d_rdata_q <= '0;
              end else begin
                if_ready_q <= 1'b1;
                if_err_q   <= 1'b1;
                if_rdata_q <= '0;
              end
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= S_RESP;
            if (gnt_d_q) begin
              d_ready_q <= 1'b1;
              if (!we_q) d_rdata_q <= mem_memData;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_memData;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          last_d_q <= gnt_d_q;
          cnt_q    <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory side is decoded from registered state so reset drops the strobes at once.
  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    mem_memRead   = 1'b0;
    mem_memWrite  = 1'b0;
    if (state_q == S_ACCESS) begin
      mem_address   = addr_q;
      mem_writeData = we_q ? wdata_q : 32'd0;
      mem_memRead   = ~we_q;
      mem_memWrite  = we_q && (cnt_q == LAST_CNT);
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;
  assign dbg_state = state_q;

endmodule
